// File: rtl/water_pump_ctrl.sv
// Tank fill controller: debounces thermometer-coded level probes and drives the pump,
// with dry-run timeout and sensor-error fault handling.
module water_pump_ctrl #(
    parameter int unsigned DEB_CYC = 4,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned LOW_TH  = 2,
    parameter int unsigned HIGH_TH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] a,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       alarm,
    output logic [3:0] level_cnt,
    output logic       lvl_valid,
    output logic       full,
    output logic       half,
    output logic       empty,
    output logic [1:0] state
);

    localparam int unsigned SW = $clog2(DEB_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] StabMax   = SW'(DEB_CYC);
    localparam logic [SW-1:0] StabLast  = SW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LowTh     = 4'(LOW_TH);
    localparam logic [3:0]    HighTh    = 4'(HIGH_TH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StFault = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    a_q;
    logic [SW-1:0] stab_q;
    logic [TW-1:0] timer_q;
    logic          sens_err_q;
    logic          accept, valid_acc, err_acc;
    logic          therm_ok;
    logic [3:0]    therm_n;
    logic [8:0]    mask;

    // Accept on the edge where the counter would reach DEB_CYC; saturation prevents re-accepting.
    assign accept    = (a == a_q) && (stab_q == StabLast);
    assign valid_acc = accept && therm_ok;
    assign err_acc   = accept && !therm_ok;

    always_comb begin
        therm_ok = 1'b0;
        therm_n  = '0;
        mask     = '0;
        for (int n = 0; n <= 8; n++) begin
            mask = (9'd1 << n) - 9'd1;
            if ({1'b0, a_q} == mask) begin
                therm_ok = 1'b1;
                therm_n  = 4'(n);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (sens_err_q) begin
            state_d = StFault;
        end else if (lvl_valid) begin
            case (state_q)
                StIdle: begin
                    if (en && level_cnt <= LowTh) state_d = StFill;
                end
                StFill: begin
                    if (timer_q == TimerLast)               state_d = StFault;
                    else if (!en || level_cnt >= HighTh)    state_d = StIdle;
                end
                StFault: begin
                    if (fault_clr && !err_acc) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            stab_q     <= '0;
            level_cnt  <= '0;
            lvl_valid  <= 1'b0;
            sens_err_q <= 1'b0;
        end else begin
            a_q <= a;
            if (a != a_q)             stab_q <= '0;
            else if (stab_q != StabMax) stab_q <= stab_q + 1'b1;
            if (valid_acc) begin
                level_cnt  <= therm_n;
                lvl_valid  <= 1'b1;
                sens_err_q <= 1'b0;
            end else if (err_acc) begin
                sens_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pump_on <= 1'b0;
            alarm   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pump_on <= (state_d == StFill);
            alarm   <= (state_d == StFault);
            // A level drop in FILL is not an increase, so it keeps the timer running.
            if (state_d != StFill || state_q != StFill)         timer_q <= '0;
            else if (valid_acc && therm_n > level_cnt)          timer_q <= '0;
            else                                                timer_q <= timer_q + 1'b1;
        end
    end

    assign state = state_q;
    assign empty = lvl_valid && (level_cnt == 4'd0);
    assign half  = lvl_valid && (level_cnt >= 4'd4);
    assign full  = lvl_valid && (level_cnt == 4'd8);

endmodule

// File: doc/water_pump_ctrl.md
WATER_PUMP_CTRL -- requirements
Module: water_pump_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 4: consecutive equal samples of a required to accept a new level.
REQ-002 Parameter TIMEOUT, default 1000: maximum cycles in FILL without a level increase.
REQ-003 Parameter LOW_TH, default 2: level_cnt at or below which filling starts.
REQ-004 Parameter HIGH_TH, default 8: level_cnt at or above which filling stops.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  controller enable; 0 forces IDLE.
REQ-008 a  input  8  tank probes; bit i=1 means water at probe i, thermometer code expected.
REQ-009 fault_clr  input  1  single-cycle request to leave FAULT.
REQ-010 pump_on  output  1  pump drive.
REQ-011 alarm  output  1  high while in FAULT.
REQ-012 level_cnt  output  4  debounced level, 0..8.
REQ-013 lvl_valid  output  1  level_cnt holds an accepted sample.
REQ-014 full, half, empty  output  1 each  level flags.
REQ-015 state  output  2  IDLE=0, FILL=1, FAULT=2; 3 unused.

Function
REQ-016 a is registered into a_q every edge; a stability counter increments while a equals a_q and clears to 0 on mismatch, saturating at DEB_CYC.
REQ-017 A new a value applied before edge E0 is reflected in level_cnt, sensor status and lvl_valid after edge E0+DEB_CYC; glitches shorter than DEB_CYC+1 cycles have no effect.
REQ-018 On acceptance: if a equals 2^n-1 (n=0..8), level_cnt=n and the sample is valid; otherwise level_cnt holds its previous value and a sensor error is flagged.
REQ-019 empty = (level_cnt==0); half = (level_cnt>=4); full = (level_cnt==8); all three are forced to 0 while lvl_valid=0.
REQ-020 The FSM evaluates transitions only while lvl_valid=1; otherwise it holds its state.
REQ-021 IDLE: pump_on=0; goes to FILL when en=1 and level_cnt<=LOW_TH.
REQ-022 FILL: pump_on=1; goes to IDLE when level_cnt>=HIGH_TH or en=0.
REQ-023 FILL dry-run timer: clears on entry to FILL and on every accepted level_cnt increase, and otherwise increments each cycle.
REQ-024 When the dry-run timer reaches TIMEOUT-1, the FSM goes to FAULT on the next edge.
REQ-025 A sensor error from any state goes to FAULT, with priority over all other transitions.
REQ-026 FAULT: pump_on=0 and alarm=1; goes to IDLE on fault_clr=1 only if no sensor error is currently flagged; en does not affect FAULT.
REQ-027 If fault_clr and a new sensor error coincide, the FSM stays in FAULT.
REQ-028 fault_clr outside FAULT is ignored.
REQ-029 pump_on and alarm are registered Moore outputs, decoded from the next-state value, so they change on the same edge as state.
REQ-030 Immediately after fault_clr with level_cnt<=LOW_TH and en=1, the FSM enters IDLE for one cycle, then FILL.
REQ-031 Level dropping during FILL does not clear the dry-run timer.

Reset
REQ-032 rst=0 asynchronously sets: state=IDLE, pump_on=0, alarm=0, level_cnt=0, lvl_valid=0, full=half=empty=0, a_q=0, stability counter=0, dry-run timer=0.
REQ-033 After rst deasserts, the first valid acceptance follows REQ-017.
REQ-034 rst asserted in any state, including mid-debounce or FAULT, takes effect immediately without waiting for a clock edge.

Verification (DEB_CYC=4, TIMEOUT=16, LOW_TH=2, HIGH_TH=8)
REQ-035 Reset release, en=1, a=8'h01: after 5 edges level_cnt=1, empty=0, lvl_valid=1; next edge state=FILL, pump_on=1.
REQ-036 Fill run: step a 03,07,...,FF, each held 10 cycles; timer never expires; at a=FF full=1, half=1, then state=IDLE, pump_on=0.
REQ-037 Dry run: a=8'h01 held in FILL; exactly 16 cycles after FILL entry state=FAULT, alarm=1, pump_on=0; then fault_clr pulse -> IDLE for one cycle, then FILL.
REQ-038 Glitch and error: a=8'h0F with a 3-cycle pulse to 8'h1F -> level_cnt stays 4; a=8'h05 held 5 cycles -> FAULT, level_cnt stays 4, fault_clr is ignored until a is a valid thermometer code.
REQ-039 Enable and reset: en=0 in FILL -> IDLE and pump_on=0 next edge; rst=0 mid-FILL between edges -> pump_on=0 immediately.
